// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
// Channel state words are MAX_W bits wide; divider widths up to MAX_W are supported.
package clk_div_pkg;
  localparam int DIV_MIN = 2;
  localparam int MAX_W   = 32;

  typedef logic [MAX_W-1:0] word_t;

  typedef struct packed {
    word_t cnt;
    word_t div;
    word_t div_nxt;
    logic  pending;
  } chan_state_t;

  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, shadow divisor and glitch-free apply logic.
// Optional CLK_DIV_SYNC_EN adds a sync input that restarts the period on demand.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = 20,
  parameter int DEFAULT_DIV = 10
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             enable,
`ifdef CLK_DIV_SYNC_EN
  input  logic             sync,
`endif
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_div,
  output logic             o_pending,
  output logic             o_clk,
  output logic             o_tick
);
  chan_state_t r_st;
  chan_state_t w_st_nxt;
  logic        r_clk;
  logic        r_tick;
  logic        w_clk_nxt;
  logic        w_tick_nxt;
  logic        w_sync;
  logic        w_run;
  logic        w_run_new;
  logic        w_last;
  logic        w_restart;
  word_t       w_div_new;
  word_t       w_cnt_inc;

`ifdef CLK_DIV_SYNC_EN
  assign w_sync = sync;
`else
  assign w_sync = 1'b0;
`endif

  assign w_run     = r_st.div >= word_t'(DIV_MIN);
  assign w_div_new = r_st.pending ? r_st.div_nxt : r_st.div;
  assign w_run_new = w_div_new >= word_t'(DIV_MIN);
  assign w_last    = r_st.cnt == (r_st.div - word_t'(1));
  assign w_cnt_inc = r_st.cnt + word_t'(1);
  // A stopped channel restarts every cycle so a pending divisor lands immediately.
  assign w_restart = !w_run || (w_run && w_sync) || (enable && w_last);

  always_comb begin
    w_st_nxt   = r_st;
    w_clk_nxt  = r_clk;
    w_tick_nxt = 1'b0;
    if (i_load) begin
      w_st_nxt.div_nxt = word_t'(i_div);
      w_st_nxt.pending = 1'b1;
    end
    if (w_restart) begin
      if (r_st.pending) begin
        w_st_nxt.div     = r_st.div_nxt;
        w_st_nxt.pending = 1'b0;
      end
      w_st_nxt.cnt = '0;
      w_clk_nxt    = w_run_new;
      w_tick_nxt   = w_run_new && (enable || w_sync);
    end else if (enable) begin
      w_st_nxt.cnt = w_cnt_inc;
      w_clk_nxt    = w_cnt_inc < (r_st.div >> 1);
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      r_st   <= '{cnt: '0, div: word_t'(DEFAULT_DIV), div_nxt: '0, pending: 1'b0};
      r_clk  <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_st   <= w_st_nxt;
      r_clk  <= w_clk_nxt;
      r_tick <= w_tick_nxt;
    end
  end

  assign o_pending = r_st.pending;
  assign o_clk     = r_clk;
  assign o_tick    = r_tick;
endmodule

// File: rtl/clk_div_multi.sv
// N-channel programmable clock divider with a shared valid/ready divisor load port.
// Defining CLK_DIV_SYNC_EN adds the sync input for phase-aligning all channels.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter  int N_CH        = 4,
  parameter  int WIDTH       = 20,
  parameter  int DEFAULT_DIV = 10,
  localparam int CHW         = chan_w(N_CH)
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CHW-1:0]   cfg_chan,
  input  logic [WIDTH-1:0] cfg_div,
`ifdef CLK_DIV_SYNC_EN
  input  logic             sync,
`endif
  output logic [N_CH-1:0]  clock_out,
  output logic [N_CH-1:0]  tick
);
  logic [N_CH-1:0] w_pending;
  logic [N_CH-1:0] w_load;

  // Out-of-range channels leave cfg_ready high so the request is consumed and dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      if (cfg_chan == CHW'(i)) cfg_ready = ~w_pending[i];
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign w_load[i] = cfg_valid && cfg_ready && (cfg_chan == CHW'(i));

    clk_div_channel #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clock_in  (clock_in),
      .reset     (reset),
      .enable    (enable),
`ifdef CLK_DIV_SYNC_EN
      .sync      (sync),
`endif
      .i_load    (w_load[i]),
      .i_div     (cfg_div),
      .o_pending (w_pending[i]),
      .o_clk     (clock_out[i]),
      .o_tick    (tick[i])
    );
  end
endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Multi-channel, runtime-programmable clock divider. Successor to the single fixed-ratio divider. Generates N independent divided clocks plus one-cycle tick strobes from `clock_in`, each with a divisor reloadable through a valid/ready port without glitching the current period. Feeds the clock's seconds, blink and display-multiplex timing.

## Interface
- `N_CH`, default 4: number of channels (1..16).
- `WIDTH`, default 20: divisor and counter width.
- `DEFAULT_DIV`, default 10: divisor loaded into every channel at reset.
- `clock_in`  in  1: clock.
- `reset`  in  1: reset; asynchronous, active-high.
- `enable`  in  1: global count enable.
- `cfg_valid`  in  1: divisor load request.
- `cfg_ready`  out  1: load accepted when high with `cfg_valid`.
- `cfg_chan`  in  CHW: target channel; CHW = max(1, clog2(N_CH)).
- `cfg_div`  in  WIDTH: new divisor D.
- `clock_out`  out  N_CH: divided clocks.
- `tick`  out  N_CH: one-cycle strobe at each period start.
- `sync`  in  1: phase-align all channels (present only with `CLK_DIV_SYNC_EN`).

## Operation
- Per channel: active divisor `div`, shadow `div_nxt`, flag `pending`, counter `cnt`.
- Reset values: `cnt`=0, `div`=DEFAULT_DIV, `pending`=0, `clock_out`=0, `tick`=0, `cfg_ready`=1.
- Channel is running when `div` ≥ 2. When `div` < 2 (0 or 1), the channel is stopped: `cnt` held at 0, `clock_out`=0, `tick`=0.
- Running with `enable`=1: `cnt` counts 0..div-1 and then wraps to 0.
- `clock_out` is registered. It is 1 when the next `cnt` < div/2 (integer division).
  - Even D gives 50% duty.
  - Odd D gives high for (D-1)/2 of D cycles.
- `tick` is registered. It is 1 for exactly the cycle in which `cnt`=0 after a wrap, i.e. coincident with the rising edge of `clock_out`.
- `enable`=0: `cnt` and `clock_out` freeze, `tick` is forced to 0, and loads are still accepted.
- Load handshake:
  - `cfg_ready` = ~`pending`[`cfg_chan`]. It is combinational from `cfg_chan`.
  - On accept: `div_nxt` ← `cfg_div` and `pending` ← 1.
  - A `cfg_chan` ≥ N_CH is accepted (`cfg_ready`=1) and discarded.
- Apply rule:
  - On a running channel, a pending divisor takes effect at the wrap: `div` ← `div_nxt`, `cnt` ← 0, `pending` ← 0. The current period always completes with the old divisor.
  - On a stopped channel, a pending divisor applies on the cycle after accept, even when `enable`=0. The channel then starts at `cnt`=0 and asserts `tick` on that cycle if it is running and `enable`=1.
- Loading a divisor < 2 stops the channel at its next wrap.
- Reset asserted mid-period or mid-load clears all state to reset values immediately; pending loads are lost.

## Timing
- Load accepted at edge k on a stopped channel: new period starts at edge k+1, with `tick` high in cycle k+1.
- Running channel, D=4, `enable` held: `tick` is high every 4th cycle and `clock_out` follows 1,1,0,0.
- No combinational path from `cfg_*` to `clock_out` or `tick`.
- `cfg_ready` drops the cycle after an accept and rises the cycle after the apply.

## Configuration
- `CLK_DIV_SYNC_EN` defined:
  - `sync` port exists.
  - `sync`=1 at edge k forces every running channel to `cnt`=0, `clock_out`=1, `tick`=1 at k+1, regardless of `enable`.
  - Pending divisors apply at that same edge.
  - `sync` has priority over the normal wrap.
- `CLK_DIV_SYNC_EN` undefined: no `sync` port and no alignment logic; channels are phase-aligned only by reset.

## Structure
- Package `clk_div_pkg` holds:
  - `DIV_MIN`=2.
  - Function `chan_w(n)` returning max(1, clog2(n)).
  - Channel state typedef {`cnt`, `div`, `div_nxt`, `pending`}.
- Sub-module `clk_div_channel` implements one channel (counter, shadow, apply logic, outputs).
- The top level instantiates `clk_div_channel` N_CH times, decodes `cfg_chan`, and muxes `cfg_ready`.

## Test plan
- Reset, then hold `enable`=1 with DEFAULT_DIV=10 → each `clock_out` is 5 high / 5 low, `tick` every 10 cycles, all channels in phase.
- Load ch1 D=3 at mid-period → old 10-cycle period completes, then ch1 `tick` every 3 cycles with high 1 of 3; `cfg_ready` low for ch1 until apply.
- Load ch2 D=0, then D=6 → ch2 stops after its wrap (outputs 0); the D=6 load restarts it the next cycle with `tick`=1.
- `enable`=0 for 7 cycles mid-period → counters and `clock_out` hold, `tick` stays 0, and the period resumes intact.
- Assert `reset` while ch0 has a pending load → outputs 0 asynchronously, divisor returns to 10, `pending` cleared.
- With `CLK_DIV_SYNC_EN`: ch0 D=4, ch1 D=6, pulse `sync` → both show `tick`=1 next cycle and both coincide again 12 cycles later.
